// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter and its
// writeback requesters.
package regfile_write_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int ZERO_REG       = 0;

  typedef struct packed {
    logic                      valid;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request, register-file write and read-forwarding signals.
// The master side is the pipeline/register-file; the slave side is the arbiter.
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  req0_valid_in;
  logic                  req0_ready_out;
  logic [ADDR_WIDTH-1:0] req0_addr_in;
  logic [DATA_WIDTH-1:0] req0_data_in;
  logic                  req1_valid_in;
  logic                  req1_ready_out;
  logic [ADDR_WIDTH-1:0] req1_addr_in;
  logic [DATA_WIDTH-1:0] req1_data_in;
  logic                  write_out;
  logic [ADDR_WIDTH-1:0] write_addr_out;
  logic [DATA_WIDTH-1:0] write_data_out;
  logic [ADDR_WIDTH-1:0] read_addr0_in;
  logic [ADDR_WIDTH-1:0] read_addr1_in;
  logic [DATA_WIDTH-1:0] file_data0_in;
  logic [DATA_WIDTH-1:0] file_data1_in;
  logic [DATA_WIDTH-1:0] read_data0_out;
  logic [DATA_WIDTH-1:0] read_data1_out;

  modport master (
    output req0_valid_in, req0_addr_in, req0_data_in,
    output req1_valid_in, req1_addr_in, req1_data_in,
    output read_addr0_in, read_addr1_in, file_data0_in, file_data1_in,
    input  req0_ready_out, req1_ready_out,
    input  write_out, write_addr_out, write_data_out,
    input  read_data0_out, read_data1_out
  );

  modport slave (
    input  req0_valid_in, req0_addr_in, req0_data_in,
    input  req1_valid_in, req1_addr_in, req1_data_in,
    input  read_addr0_in, read_addr1_in, file_data0_in, file_data1_in,
    output req0_ready_out, req1_ready_out,
    output write_out, write_addr_out, write_data_out,
    output read_data0_out, read_data1_out
  );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. The last-grant pointer moves only when a grant
// is issued, so a stalled loser keeps priority for the next conflict.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_last;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  // Resetting to 1 hands the very first conflict to requester 0.
  always_ff @(posedge clk) begin
    if (reset)        r_last <= 1'b1;
    else if (|o_gnt)  r_last <= o_gnt[1];
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load/CSR writeback, with
// a one-stage write register and forwarding of the in-flight write to readers.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DEPTH        = 32,
  parameter bit ZERO_DISCARD = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  bus,
  input  logic                    debugen_in,
  output logic [15:0]             conflict_count_out
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ZERO_A    = ADDR_WIDTH'(ZERO_REG);

  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic                  w_hs;
  logic                  w_drop;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  logic                  r_wv;
  logic [ADDR_WIDTH-1:0] r_wa;
  logic [DATA_WIDTH-1:0] r_wd;

  assign w_req = {bus.req1_valid_in, bus.req0_valid_in};

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .i_en  (!reset),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign bus.req0_ready_out = w_gnt[0];
  assign bus.req1_ready_out = w_gnt[1];

  assign w_hs   = |w_gnt;
  assign w_addr = w_gnt[1] ? bus.req1_addr_in : bus.req0_addr_in;
  assign w_data = w_gnt[1] ? bus.req1_data_in : bus.req0_data_in;

  // Dropped writes still handshake so the requester is never stalled on them.
  assign w_drop = (ZERO_DISCARD && (w_addr == ZERO_A)) ||
                  ({1'b0, w_addr} >= DEPTH_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wv <= 1'b0;
      r_wa <= '0;
      r_wd <= '0;
    end else begin
      r_wv <= w_hs && !w_drop;
      r_wa <= w_addr;
      r_wd <= w_data;
    end
  end

  assign bus.write_out      = r_wv;
  assign bus.write_addr_out = r_wa;
  assign bus.write_data_out = r_wd;

  always_ff @(posedge clk) begin
    if (reset)
      conflict_count_out <= 16'd0;
    else if (&w_req && (conflict_count_out != 16'hFFFF))
      conflict_count_out <= conflict_count_out + 16'd1;
  end

  // The file only holds a write from the cycle after write_out, so the
  // pipeline register is the freshest copy while it is valid.
  always_comb begin
    bus.read_data0_out = bus.file_data0_in;
    if (ZERO_DISCARD && (bus.read_addr0_in == ZERO_A))
      bus.read_data0_out = '0;
    else if (r_wv && (r_wa == bus.read_addr0_in))
      bus.read_data0_out = r_wd;
  end

  always_comb begin
    bus.read_data1_out = bus.file_data1_in;
    if (ZERO_DISCARD && (bus.read_addr1_in == ZERO_A))
      bus.read_data1_out = '0;
    else if (r_wv && (r_wa == bus.read_addr1_in))
      bus.read_data1_out = r_wd;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (debugen_in)
      $display("rfwa t=%0t gnt=%b wv=%b wa=%0d wd=%h rd0=%h rd1=%h",
               $time, w_gnt, r_wv, r_wa, r_wd,
               bus.read_data0_out, bus.read_data1_out);
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scenario bench for regfile_write_arbiter: expected file writes go into a
// queue as handshakes are predicted and are popped when write_out is seen.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        debugen;
  logic [15:0] conflict_count;

  int      n_vec = 0;
  int      n_err = 0;
  int      ptr_m = 1;
  wb_req_t exp_q[$];

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  regfile_write_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(32), .ZERO_DISCARD(1'b1)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus),
    .debugen_in         (debugen),
    .conflict_count_out (conflict_count)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic scoreboard_mon();
    wb_req_t e;
    forever begin
      @(negedge clk);
      if (bus.write_out === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL wr_unexpected got addr=%h data=%h exp no write",
                   bus.write_addr_out, bus.write_data_out);
        end else begin
          e = exp_q.pop_front();
          if (bus.write_addr_out !== e.addr || bus.write_data_out !== e.data) begin
            n_err++;
            $display("FAIL wr_data got addr=%h data=%h exp addr=%h data=%h",
                     bus.write_addr_out, bus.write_data_out, e.addr, e.data);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req0_valid_in = 1'b1;
    bus.req1_valid_in = 1'b1;
    cyc();
    @(negedge clk);
    n_vec++;
    if (bus.req0_ready_out !== 1'b0 || bus.req1_ready_out !== 1'b0) begin
      n_err++; $display("FAIL rst_ready got=%b%b exp=00", bus.req1_ready_out, bus.req0_ready_out);
    end
    n_vec++;
    if (bus.write_out !== 1'b0) begin
      n_err++; $display("FAIL rst_write got=%b exp=0", bus.write_out);
    end
    n_vec++;
    if (conflict_count !== 16'd0) begin
      n_err++; $display("FAIL rst_count got=%0d exp=0", conflict_count);
    end
    cyc();
    reset = 1'b0;
    bus.req0_valid_in = 1'b0;
    bus.req1_valid_in = 1'b0;
    ptr_m = 1;
  endtask

  task automatic test_single();
    bus.req0_addr_in  = 8'd5;
    bus.req0_data_in  = 32'hDEADBEEF;
    bus.req0_valid_in = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.req0_ready_out !== 1'b1 || bus.req1_ready_out !== 1'b0) begin
      n_err++; $display("FAIL single_ready got=%b%b exp=01", bus.req1_ready_out, bus.req0_ready_out);
    end
    exp_q.push_back('{valid: 1'b1, addr: 8'd5, data: 32'hDEADBEEF});
    ptr_m = 0;
    cyc();
    bus.req0_valid_in = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.write_out !== 1'b1) begin
      n_err++; $display("FAIL single_wr_t1 got=%b exp=1", bus.write_out);
    end
    cyc();
    @(negedge clk);
    n_vec++;
    if (bus.write_out !== 1'b0) begin
      n_err++; $display("FAIL single_wr_t2 got=%b exp=0", bus.write_out);
    end
    cyc();
  endtask

  task automatic test_conflict();
    int g;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    ptr_m = 1;
    bus.req0_addr_in = 8'd10;
    bus.req0_data_in = 32'h100;
    bus.req1_addr_in = 8'd11;
    bus.req1_data_in = 32'h200;
    bus.req0_valid_in = 1'b1;
    bus.req1_valid_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      g = (ptr_m == 1) ? 0 : 1;
      n_vec++;
      if (bus.req0_ready_out !== (g == 0) || bus.req1_ready_out !== (g == 1)) begin
        n_err++; $display("FAIL conflict_gnt%0d got=%b%b exp_port=%0d", k,
                          bus.req1_ready_out, bus.req0_ready_out, g);
      end
      if (g == 0) exp_q.push_back('{valid: 1'b1, addr: 8'd10, data: bus.req0_data_in});
      else        exp_q.push_back('{valid: 1'b1, addr: 8'd11, data: bus.req1_data_in});
      ptr_m = g;
      cyc();
      if (g == 0) bus.req0_data_in = 32'h100 + 32'(k + 1);
      else        bus.req1_data_in = 32'h200 + 32'(k + 1);
    end
    bus.req0_valid_in = 1'b0;
    bus.req1_valid_in = 1'b0;
    @(negedge clk);
    n_vec++;
    if (conflict_count !== 16'd4) begin
      n_err++; $display("FAIL conflict_count got=%0d exp=4", conflict_count);
    end
    cyc();
    cyc();
  endtask

  task automatic test_forward();
    bus.req0_addr_in  = 8'd7;
    bus.req0_data_in  = 32'h11;
    bus.req0_valid_in = 1'b1;
    @(negedge clk);
    exp_q.push_back('{valid: 1'b1, addr: 8'd7, data: 32'h11});
    ptr_m = 0;
    cyc();
    bus.req0_valid_in = 1'b0;
    bus.read_addr0_in = 8'd7;
    bus.read_addr1_in = 8'd7;
    bus.file_data0_in = 32'h0;
    bus.file_data1_in = 32'h0;
    @(negedge clk);
    n_vec++;
    if (bus.read_data0_out !== 32'h11 || bus.read_data1_out !== 32'h11) begin
      n_err++; $display("FAIL fwd_inflight got=%h/%h exp=11/11", bus.read_data0_out, bus.read_data1_out);
    end
    cyc();
    bus.file_data0_in = 32'h11;
    bus.file_data1_in = 32'h77;
    @(negedge clk);
    n_vec++;
    if (bus.read_data0_out !== 32'h11 || bus.read_data1_out !== 32'h77) begin
      n_err++; $display("FAIL fwd_file got=%h/%h exp=11/77", bus.read_data0_out, bus.read_data1_out);
    end
    cyc();
  endtask

  task automatic test_drop();
    bus.req1_addr_in  = 8'd0;
    bus.req1_data_in  = 32'h55;
    bus.req1_valid_in = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.req1_ready_out !== 1'b1) begin
      n_err++; $display("FAIL drop0_ready got=%b exp=1", bus.req1_ready_out);
    end
    ptr_m = 1;
    cyc();
    bus.req1_addr_in  = 8'd40;
    bus.req1_data_in  = 32'h66;
    bus.read_addr0_in = 8'd0;
    bus.read_addr1_in = 8'd0;
    bus.file_data0_in = 32'hFF;
    bus.file_data1_in = 32'hFF;
    @(negedge clk);
    n_vec++;
    if (bus.req1_ready_out !== 1'b1 || bus.write_out !== 1'b0) begin
      n_err++; $display("FAIL drop0_write got ready=%b wr=%b exp ready=1 wr=0",
                        bus.req1_ready_out, bus.write_out);
    end
    n_vec++;
    if (bus.read_data0_out !== 32'h0 || bus.read_data1_out !== 32'h0) begin
      n_err++; $display("FAIL zero_read got=%h/%h exp=0/0", bus.read_data0_out, bus.read_data1_out);
    end
    cyc();
    bus.req1_valid_in = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.write_out !== 1'b0) begin
      n_err++; $display("FAIL drop_depth got wr=%b exp=0", bus.write_out);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    debugen = 1'b1;
    bus.req0_addr_in  = 8'd3;
    bus.req0_data_in  = 32'hA;
    bus.req0_valid_in = 1'b1;
    @(negedge clk);
    exp_q.push_back('{valid: 1'b1, addr: 8'd3, data: 32'hA});
    ptr_m = 0;
    cyc();
    bus.req0_data_in  = 32'hB;
    bus.read_addr1_in = 8'd3;
    bus.file_data1_in = 32'h0;
    @(negedge clk);
    n_vec++;
    if (bus.req0_ready_out !== 1'b1 || bus.read_data1_out !== 32'hA) begin
      n_err++; $display("FAIL b2b_first got ready=%b rd1=%h exp ready=1 rd1=a",
                        bus.req0_ready_out, bus.read_data1_out);
    end
    exp_q.push_back('{valid: 1'b1, addr: 8'd3, data: 32'hB});
    cyc();
    bus.req0_valid_in = 1'b0;
    bus.file_data1_in = 32'hA;
    @(negedge clk);
    n_vec++;
    if (bus.write_out !== 1'b1 || bus.read_data1_out !== 32'hB) begin
      n_err++; $display("FAIL b2b_second got wr=%b rd1=%h exp wr=1 rd1=b",
                        bus.write_out, bus.read_data1_out);
    end
    cyc();
    debugen = 1'b0;
    cyc();
  endtask

  task automatic test_reset_inflight();
    bus.req0_addr_in  = 8'd9;
    bus.req0_data_in  = 32'h99;
    bus.req0_valid_in = 1'b1;
    @(negedge clk);
    exp_q.push_back('{valid: 1'b1, addr: 8'd9, data: 32'h99});
    cyc();
    bus.req0_valid_in = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    ptr_m = 1;
    @(negedge clk);
    n_vec++;
    if (bus.write_out !== 1'b0 || conflict_count !== 16'd0) begin
      n_err++; $display("FAIL rst_inflight got wr=%b cnt=%0d exp wr=0 cnt=0",
                        bus.write_out, conflict_count);
    end
    cyc();
    bus.req0_addr_in  = 8'd12;
    bus.req0_data_in  = 32'hC0;
    bus.req1_addr_in  = 8'd13;
    bus.req1_data_in  = 32'hD0;
    bus.req0_valid_in = 1'b1;
    bus.req1_valid_in = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.req0_ready_out !== 1'b1 || bus.req1_ready_out !== 1'b0) begin
      n_err++; $display("FAIL rst_next_gnt got=%b%b exp=01", bus.req1_ready_out, bus.req0_ready_out);
    end
    exp_q.push_back('{valid: 1'b1, addr: 8'd12, data: 32'hC0});
    ptr_m = 0;
    cyc();
    bus.req0_valid_in = 1'b0;
    bus.req1_valid_in = 1'b0;
    @(negedge clk);
    n_vec++;
    if (conflict_count !== 16'd1) begin
      n_err++; $display("FAIL rst_next_count got=%0d exp=1", conflict_count);
    end
    cyc();
    cyc();
  endtask

  initial begin
    reset             = 1'b1;
    debugen           = 1'b0;
    bus.req0_valid_in = 1'b0;
    bus.req0_addr_in  = '0;
    bus.req0_data_in  = '0;
    bus.req1_valid_in = 1'b0;
    bus.req1_addr_in  = '0;
    bus.req1_data_in  = '0;
    bus.read_addr0_in = '0;
    bus.read_addr1_in = '0;
    bus.file_data0_in = '0;
    bus.file_data1_in = '0;
    fork
      scoreboard_mon();
    join_none

    test_reset();
    test_single();
    test_conflict();
    test_forward();
    test_drop();
    test_back_to_back();
    test_reset_inflight();

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL sb_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: port 0 for ALU writeback and port 1 for load/CSR writeback. It uses round-robin arbitration with a one-stage registered write pipeline. It also forwards the in-flight write onto both read ports, so readers never see stale data during the write-latency window. It sits between the execute/memory writeback stages and the register file, in front of its write/read ports.

Parameters:
DATA_WIDTH, 32, width of write/read data
ADDR_WIDTH, 8, width of register address
DEPTH, 32, number of valid registers; addresses >= DEPTH are accepted and dropped
ZERO_DISCARD, 1, when 1, writes to address 0 are accepted but never issued; reads of address 0 return 0

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req0_valid_in  in  1  requester 0 has a write
req0_ready_out  out  1  requester 0 granted this cycle
req0_addr_in  in  ADDR_WIDTH  requester 0 destination
req0_data_in  in  DATA_WIDTH  requester 0 data
req1_valid_in  in  1  requester 1 has a write
req1_ready_out  out  1  requester 1 granted this cycle
req1_addr_in  in  ADDR_WIDTH  requester 1 destination
req1_data_in  in  DATA_WIDTH  requester 1 data
write_out  out  1  register file write enable
write_addr_out  out  ADDR_WIDTH  register file write address
write_data_out  out  DATA_WIDTH  register file write data
read_addr0_in  in  ADDR_WIDTH  read port 0 address (also drives the file)
read_addr1_in  in  ADDR_WIDTH  read port 1 address
file_data0_in  in  DATA_WIDTH  register file read data 0
file_data1_in  in  DATA_WIDTH  register file read data 1
read_data0_out  out  DATA_WIDTH  forwarded read data 0
read_data1_out  out  DATA_WIDTH  forwarded read data 1
conflict_count_out  out  16  saturating count of cycles with both requesters valid
debugen_in  in  1  enable per-cycle trace print

Behaviour:
- Arbitration is combinational. A single valid requester is granted.
- When both requesters are valid, the grant goes to the requester not granted last time (the last-grant pointer).
  - The pointer updates only on a grant.
  - Reset value 1, so port 0 wins the first conflict.
- readyN_out = grantN. A handshake occurs when validN && readyN in the same cycle. The ungranted requester must hold its request stable.
- Pipeline register {wv, wa, wd} is loaded on every edge: wv = any handshake && !drop, where drop = (ZERO_DISCARD && addr==0) || addr >= DEPTH.
- write_out = wv, write_addr_out = wa, write_data_out = wd.
  - Latency: handshake at cycle t, file write asserted during t+1, file holds the value from t+2.
- Forwarding (combinational) for each read port k:
  - If ZERO_DISCARD && read_addrk==0, output 0.
  - Else if wv && wa==read_addrk, output wd.
  - Else output file_datak_in.
- Same-address back-to-back writes: the younger write overwrites the pipeline register. The file receives both writes in order; forwarding always shows the youngest.
- conflict_count_out increments when req0_valid && req1_valid and saturates at 0xFFFF.
- Reset (synchronous):
  - wv=0, wa=0, wd=0 (so write_out=0)
  - pointer=1, conflict_count_out=0
  - both ready outputs are 0 while reset is high
  - a write in flight at reset is discarded
- When debugen_in=1, print one line per cycle: grant, pipeline register, forwarded values.

Decomposition:
- Shared package: the wb_req_t struct {valid, addr, data}, ADDR_WIDTH/DATA_WIDTH defaults, and the zero-register constant.
- One natural sub-module, rr_arbiter2: a 2-way round-robin arbiter with a last-grant pointer that updates on accept, reusable for the memory-port arbiter.
- Forwarding muxes stay inline.

Test Plan:
- Only req0 valid, addr=5, data=0xDEADBEEF at t: req0_ready=1 at t; write_out=1, addr=5, data=0xDEADBEEF at t+1; write_out=0 at t+2.
- Both valid for 4 cycles out of reset, holding on stall: grants go 0,1,0,1; conflict_count_out=4; write data sequence follows the grant order.
- Write addr=7, data=0x11 at t; read_addr0_in=7 at t+1 with file_data0_in=0x0 gives read_data0_out=0x11. At t+2 the value comes from the file.
- req1 addr=0, data=0x55 with ZERO_DISCARD=1: ready=1 and write_out stays 0. Reading addr 0 returns 0 even if file_data=0xFF. Addr=40 with DEPTH=32 is also dropped.
- Back-to-back writes to addr 3 (0xA then 0xB): write_out is high two cycles with 0xA then 0xB. A read of 3 during the second cycle returns 0xB.
- Reset asserted the cycle after a handshake: write_out=0 next cycle, count=0. The next conflict is granted to req0.
